// File: rtl/cam_pkg.sv
// Shared frame geometry, default widths and capture state encoding for the
// camera frame sequencer and its frame checker.
package cam_pkg;

    localparam int FRAME_W     = 640;
    localparam int FRAME_H     = 480;
    localparam int PIX_TOTAL   = FRAME_W * FRAME_H;
    localparam int ADDR_W      = 19;
    localparam int DATA_W      = 12;
    localparam int BANK_ADDR_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_ARM     = 2'd2,
        ST_CAPTURE = 2'd3
    } cap_state_e;

endpackage

// File: rtl/cam_frame_checker.sv
// Counts in-range pixels of one captured frame and tracks out-of-range
// addresses; the verdict includes the pixel presented in the current cycle.
module cam_frame_checker
    import cam_pkg::*;
#(
    parameter int PIX_TOTAL = cam_pkg::PIX_TOTAL,
    parameter int ADDR_W    = cam_pkg::ADDR_W
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              clear,
    input  logic              pix_valid,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic              addr_ok,
    output logic              frame_good
);

    localparam logic [ADDR_W:0] PIX_TOTAL_C = (ADDR_W + 1)'(PIX_TOTAL);
    localparam logic [ADDR_W:0] CNT_MAX     = {(ADDR_W + 1){1'b1}};

    logic [ADDR_W:0] count_q;
    logic [ADDR_W:0] count_d;
    logic            ovf_q;
    logic            ovf_d;

    // Next count/overflow and verdict; the counter saturates rather than wraps.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        addr_ok = ({1'b0, pix_addr} < PIX_TOTAL_C);
        if (clear) begin
            count_d = {(ADDR_W + 1){1'b0}};
            ovf_d   = 1'b0;
        end else if (pix_valid) begin
            if (!addr_ok) begin
                ovf_d = 1'b1;
            end else if (count_q != CNT_MAX) begin
                count_d = count_q + {{ADDR_W{1'b0}}, 1'b1};
            end else begin
                count_d = count_q;
            end
        end else begin
            count_d = count_q;
        end
        frame_good = (count_d == PIX_TOTAL_C) && !ovf_d;
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge pclk) begin
        if (reset) begin
            count_q <= {(ADDR_W + 1){1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/cam_frame_sequencer.sv
// Capture sequencer: waits for a frame boundary, gates one frame of pixel writes
// into the write bank, then swaps banks and hands the frame to the consumer.
module cam_frame_sequencer
    import cam_pkg::*;
#(
    parameter int PIX_TOTAL = cam_pkg::PIX_TOTAL,
    parameter int ADDR_W    = cam_pkg::ADDR_W,
    parameter int DATA_W    = cam_pkg::DATA_W
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vsync,
    input  logic              pix_ena,
    input  logic [ADDR_W-1:0] pix_addr,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              cap_req,
    input  logic              cap_continuous,
    input  logic              rd_done,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_bank,
    output logic              frame_ready,
    output logic              frame_err,
    output logic              frame_drop,
    output logic              busy,
    output logic [7:0]        frame_count
);

    cap_state_e        state_q, state_d;
    logic              vs_q, vs_prev_q;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              drop_q, drop_d;
    logic              busy_q, busy_d;
    logic [7:0]        count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic vs_rise_s, vs_fall_s, pix_valid_s, clear_s, addr_ok_s, frame_good_s;

    cam_frame_checker #(
        .PIX_TOTAL (PIX_TOTAL),
        .ADDR_W    (ADDR_W)
    ) u_checker (
        .pclk       (pclk),
        .reset      (reset),
        .clear      (clear_s),
        .pix_valid  (pix_valid_s),
        .pix_addr   (pix_addr),
        .addr_ok    (addr_ok_s),
        .frame_good (frame_good_s)
    );

    // Sequencer next state, bank handshake and write-port qualification.
    always_comb begin
        vs_rise_s   = vs_q & ~vs_prev_q;
        vs_fall_s   = ~vs_q & vs_prev_q;
        pix_valid_s = (state_q == ST_CAPTURE) & pix_ena;
        clear_s     = (state_q == ST_ARM) & vs_rise_s;

        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        count_d   = count_q;
        err_d     = 1'b0;
        drop_d    = 1'b0;
        // A release in the evaluation cycle is honoured before the verdict.
        ready_d   = ready_q & ~rd_done;

        wr_en_d   = pix_valid_s & addr_ok_s;
        wr_addr_d = {wr_bank_q, pix_addr};
        wr_data_d = pix_data;

        case (state_q)
            ST_IDLE: begin
                if (cap_req) state_d = ST_SYNC;
                else         state_d = ST_IDLE;
            end
            ST_SYNC: begin
                if (!vs_q) state_d = ST_ARM;
                else       state_d = ST_SYNC;
            end
            ST_ARM: begin
                if (vs_rise_s) state_d = ST_CAPTURE;
                else           state_d = ST_ARM;
            end
            ST_CAPTURE: begin
                if (vs_fall_s) begin
                    state_d = cap_continuous ? ST_ARM : ST_IDLE;
                    if (!frame_good_s) begin
                        err_d = 1'b1;
                    end else if (!ready_d) begin
                        rd_bank_d = wr_bank_q;
                        wr_bank_d = ~wr_bank_q;
                        ready_d   = 1'b1;
                        count_d   = count_q + 8'd1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else begin
                    state_d = ST_CAPTURE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // All sequencer state and registered outputs.
    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= 8'd0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= {(ADDR_W + 1){1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
        end else begin
            state_q   <= state_d;
            vs_q      <= vsync;
            vs_prev_q <= vs_q;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign rd_bank     = rd_bank_q;
    assign frame_ready = ready_q;
    assign frame_err   = err_q;
    assign frame_drop  = drop_q;
    assign busy        = busy_q;
    assign frame_count = count_q;

endmodule

// File: tb/tb_cam_frame_sequencer.sv
// Scoreboard bench for cam_frame_sequencer on a reduced 16-pixel frame with a
// frame-level reference model and randomized frames.
module tb_cam_frame_sequencer;

    localparam int PIX = 16;
    localparam int AW  = 5;
    localparam int DW  = 12;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          vsync = 1'b0;
    logic          pix_ena = 1'b0;
    logic [AW-1:0] pix_addr = '0;
    logic [DW-1:0] pix_data = '0;
    logic          cap_req = 1'b0;
    logic          cap_continuous = 1'b0;
    logic          rd_done = 1'b0;
    logic          wr_en;
    logic [AW:0]   wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_bank, frame_ready, frame_err, frame_drop, busy;
    logic [7:0]    frame_count;

    cam_frame_sequencer #(.PIX_TOTAL(PIX), .ADDR_W(AW), .DATA_W(DW)) dut (
        .pclk(pclk), .reset(reset), .vsync(vsync), .pix_ena(pix_ena),
        .pix_addr(pix_addr), .pix_data(pix_data), .cap_req(cap_req),
        .cap_continuous(cap_continuous), .rd_done(rd_done), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank),
        .frame_ready(frame_ready), .frame_err(frame_err), .frame_drop(frame_drop),
        .busy(busy), .frame_count(frame_count)
    );

    always #5 pclk = ~pclk;

    typedef struct { logic [AW:0] addr; logic [DW-1:0] data; } wr_t;
    // kind: 0 = delivered, 1 = error, 2 = dropped
    typedef struct { int kind; logic rd; logic rdy; logic [7:0] cnt; logic bsy; } evt_t;

    wr_t  exp_wr[$];
    evt_t exp_evt[$];
    int   total = 0;
    int   bad = 0;

    // Frame-level model of the sequencer
    bit       m_active = 1'b0;
    logic     m_wrb = 1'b0, m_rd = 1'b0, m_rdy = 1'b0;
    logic [7:0] m_cnt = 8'd0;

    logic [7:0] prev_cnt;
    wr_t  w;
    evt_t e;
    int   k;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // Monitor: pop and compare whenever the DUT presents a write or a frame event.
    always @(negedge pclk) begin
        if (reset) begin
            prev_cnt = frame_count;
        end else begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got addr %0h, want no write", wr_addr);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", wr_addr, w.addr);
                    chk("wr_data", wr_data, w.data);
                end
            end
            if (frame_err || frame_drop || frame_count != prev_cnt) begin
                k = frame_err ? 1 : (frame_drop ? 2 : 0);
                if (exp_evt.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_event: got kind %0d, want none", k);
                end else begin
                    e = exp_evt.pop_front();
                    chk("evt_kind", k, e.kind);
                    chk("err_drop_excl", frame_err & frame_drop, 0);
                    chk("rd_bank", rd_bank, e.rd);
                    chk("frame_ready", frame_ready, e.rdy);
                    chk("frame_count", frame_count, e.cnt);
                    chk("busy_after_eval", busy, e.bsy);
                end
            end
            prev_cnt = frame_count;
        end
    end

    task automatic request();
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        if (!m_active) m_active = 1'b1;
        repeat (2) tick();
    endtask

    task automatic release_bank();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        m_rdy = 1'b0;
        chk("ready_cleared", frame_ready, 0);
    endtask

    // One frame: n_in in-range pixels plus n_ovf out-of-range pixels at random positions.
    task automatic send_frame(input int n_in, input int n_ovf, input bit cont,
                              input bit rd_at_fall, input int req_at, input int rst_at);
        int addrs[$];
        bit cap;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        for (int i = 0; i < n_in; i++) addrs.push_back(i % PIX);
        for (int j = 0; j < n_ovf; j++)
            addrs.insert($urandom_range(0, addrs.size()), PIX + $urandom_range(0, (1 << AW) - 1 - PIX));
        cap_continuous = cont;
        vsync = 1'b1;
        cap = m_active;
        repeat (3) tick();
        for (int i = 0; i < addrs.size(); i++) begin
            d = DW'($urandom);
            a = AW'(addrs[i]);
            pix_ena = 1'b1; pix_addr = a; pix_data = d;
            if (i == rst_at) begin
                reset = 1'b1;
                tick();
                pix_ena = 1'b0;
                chk("rst_wr_en", wr_en, 0);
                chk("rst_wr_addr", wr_addr, 0);
                chk("rst_wr_data", wr_data, 0);
                chk("rst_rd_bank", rd_bank, 0);
                chk("rst_ready", frame_ready, 0);
                chk("rst_err", frame_err, 0);
                chk("rst_drop", frame_drop, 0);
                chk("rst_busy", busy, 0);
                chk("rst_count", frame_count, 0);
                chk("rst_pending_writes", exp_wr.size(), 0);
                tick();
                reset = 1'b0;
                m_active = 1'b0; m_wrb = 1'b0; m_rd = 1'b0; m_rdy = 1'b0; m_cnt = 8'd0;
                cap = 1'b0;
                continue;
            end
            if (i == req_at) begin
                cap_req = 1'b1;
                if (!m_active) m_active = 1'b1;
            end
            if (cap && addrs[i] < PIX) exp_wr.push_back('{addr: {m_wrb, a}, data: d});
            tick();
            pix_ena = 1'b0; cap_req = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (2) tick();
        vsync = 1'b0;
        tick();
        rd_done = rd_at_fall;
        tick();
        rd_done = 1'b0;
        if (rd_at_fall) m_rdy = 1'b0;
        if (cap) begin
            if (!(n_in == PIX && n_ovf == 0)) begin
                k = 1;
            end else if (!m_rdy) begin
                m_rd = m_wrb; m_wrb = ~m_wrb; m_rdy = 1'b1; m_cnt = m_cnt + 8'd1; k = 0;
            end else begin
                k = 2;
            end
            m_active = cont;
            exp_evt.push_back('{kind: k, rd: m_rd, rdy: m_rdy, cnt: m_cnt, bsy: cont});
        end
        repeat (4) tick();
    endtask

    initial begin
        int n_in, n_ovf;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("init_wr_en", wr_en, 0);
        chk("init_rd_bank", rd_bank, 0);
        chk("init_ready", frame_ready, 0);
        chk("init_busy", busy, 0);
        chk("init_count", frame_count, 0);

        // single-shot clean frame
        request();
        chk("busy_after_req", busy, 1);
        send_frame(PIX, 0, 1'b0, 1'b0, -1, -1);
        // no request: frame ignored
        send_frame(PIX, 0, 1'b0, 1'b0, -1, -1);
        release_bank();
        // request in the middle of a frame, then the next frame is delivered
        send_frame(PIX, 0, 1'b0, 1'b0, 5, -1);
        send_frame(PIX, 0, 1'b0, 1'b0, -1, -1);
        release_bank();
        // short frame
        request();
        send_frame(PIX - 1, 0, 1'b0, 1'b0, -1, -1);
        // continuous with a held consumer
        request();
        send_frame(PIX, 0, 1'b1, 1'b0, -1, -1);
        send_frame(PIX, 0, 1'b1, 1'b0, -1, -1);
        send_frame(PIX, 0, 1'b1, 1'b0, -1, -1);
        release_bank();
        send_frame(PIX, 0, 1'b1, 1'b0, -1, -1);
        // release coinciding with a good-frame evaluation, then stop
        send_frame(PIX, 0, 1'b0, 1'b1, -1, -1);
        release_bank();
        // overflow pixel
        request();
        send_frame(PIX, 1, 1'b0, 1'b0, -1, -1);

        // randomized frames
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 9) < 6) request();
            case ($urandom_range(0, 4))
                0: begin n_in = PIX - 1; n_ovf = 0; end
                1: begin n_in = PIX; n_ovf = 1; end
                2: begin n_in = PIX + 1; n_ovf = 0; end
                default: begin n_in = PIX; n_ovf = 0; end
            endcase
            send_frame(n_in, n_ovf, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
            if ($urandom_range(0, 2) == 0) release_bank();
        end

        // reset in the middle of a capture, then a fresh capture lands in bank 0
        cap_continuous = 1'b0;
        request();
        send_frame(PIX, 0, 1'b1, 1'b0, -1, 6);
        request();
        send_frame(PIX, 0, 1'b0, 1'b0, -1, -1);

        repeat (5) tick();
        chk("writes_drained", exp_wr.size(), 0);
        chk("events_drained", exp_evt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_frame_sequencer.md
# cam_frame_sequencer

Capture sequencer between the camera pixel assembler and the dual-bank frame RAM. On request it waits for a clean frame boundary, gates RAM writes for exactly one full frame into the current write bank, validates the pixel count, and on success swaps banks and hands the finished frame to the recognition/display consumer with a ready/done handshake. It supports single-shot and continuous capture, and drops frames while the consumer still holds the read bank.

## Interface
**Parameters**
- `PIX_TOTAL`, default 307200: pixels per valid frame (640×480).
- `ADDR_W`, default 19: pixel address width within one bank.
- `DATA_W`, default 12: pixel width (RGB444).

**Ports**
- `pclk`, in, 1: camera pixel clock; the block's single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `vsync`, in, 1: camera frame sync. High means an active frame; low means a blanking/reset interval.
- `pix_ena`, in, 1: one-cycle strobe marking a new assembled pixel.
- `pix_addr`, in, ADDR_W: upstream pixel address.
- `pix_data`, in, DATA_W: upstream RGB444 pixel.
- `cap_req`, in, 1: one-cycle capture request.
- `cap_continuous`, in, 1: level. 1 = continuous, 0 = single-shot.
- `rd_done`, in, 1: one-cycle pulse; the consumer releases the read bank.
- `wr_en`, out, 1: RAM write enable.
- `wr_addr`, out, ADDR_W+1: {write bank, pixel address}.
- `wr_data`, out, DATA_W: RAM write data.
- `rd_bank`, out, 1: bank the consumer may read.
- `frame_ready`, out, 1: level; `rd_bank` holds a complete, valid frame.
- `frame_err`, out, 1: one-cycle pulse; a captured frame was discarded as malformed.
- `frame_drop`, out, 1: one-cycle pulse; a valid frame was discarded because the consumer was busy.
- `busy`, out, 1: state is not IDLE.
- `frame_count`, out, 8: number of valid frames delivered, wrapping.

## Operation
- `vsync` is registered once to form `vs_rise` (start of frame) and `vs_fall` (end of frame).
- **States**
  - IDLE: `cap_req` → SYNC.
  - SYNC: wait for `vsync` low, so a partial frame is never captured. Then → ARM.
  - ARM: `vs_rise` → CAPTURE, with pixel counter cleared.
  - CAPTURE: each `pix_ena` with `pix_addr < PIX_TOTAL` issues a write and increments the counter. A `pix_ena` with `pix_addr ≥ PIX_TOTAL` writes nothing and sets a sticky overflow flag. `vs_fall` → evaluate.
- **Evaluate** happens on the `vs_fall` cycle itself; there is no extra state.
  - Frame is bad (count ≠ PIX_TOTAL or overflow set): pulse `frame_err`. The write bank is unchanged. Go to ARM in continuous mode, IDLE in single-shot mode.
  - Frame is good and `frame_ready` = 0: set `rd_bank` to the current write bank, toggle the write bank, set `frame_ready`, increment `frame_count`. Go to ARM in continuous mode, IDLE in single-shot mode.
  - Frame is good and `frame_ready` = 1: pulse `frame_drop` and overwrite the same bank next time. Go to ARM in continuous mode, IDLE in single-shot mode.
- `rd_done` clears `frame_ready`. If `rd_done` and a good-frame evaluation occur in the same cycle, `rd_done` is applied first, so the swap proceeds.
- `cap_req` is ignored outside IDLE. Clearing `cap_continuous` during capture finishes the current frame and then returns to IDLE.
- Pixel counter is ADDR_W+1 bits and saturates at all-ones.

## Timing
- Write latency is 1 `pclk`: `wr_en`, `wr_addr`, and `wr_data` are registered copies of the qualified `pix_ena`, `pix_addr`, and `pix_data`.
- `vs_rise`/`vs_fall` lag `vsync` by 1 cycle. A `pix_ena` in the same cycle as `vs_fall` is still counted and written.
- `frame_ready`, `rd_bank`, and `frame_count` update 1 cycle after `vs_fall` is detected. `frame_err` and `frame_drop` are high for exactly that cycle.
- `busy` goes high the cycle after `cap_req` is accepted.
- **Reset values:** all outputs 0, write bank 0, state IDLE, counters and flags cleared.
- **Reset mid-frame:** writes stop on the next edge, no frame is delivered, and the bank reverts to 0.

## Structure
- Shared package/header `cam_pkg`: `PIX_TOTAL`, frame geometry, state encoding (IDLE, SYNC, ARM, CAPTURE), and bank-address concatenation width.
- One natural sub-module: `cam_frame_checker`. It holds the pixel counter, overflow flag, and good/bad verdict, cleared on ARM→CAPTURE.
- The top level holds the FSM, bank/handshake registers, and write-port registers.

## Test plan
- **Single-shot, clean frame.** Stimulus: `cap_req`, then a full 307200-pixel frame. Required: 307200 writes with `wr_addr[19]` = 0. After `vs_fall`: `frame_ready` = 1, `rd_bank` = 0, `frame_count` = 1, state IDLE, `busy` = 0.
- **Request mid-frame.** Stimulus: `cap_req` while `vsync` is high with 1000 pixels already streamed. Required: no writes until after the next `vsync` low→high. The following full frame is delivered.
- **Short frame.** Stimulus: 307199 pixels. Required: `frame_err` pulses once, `frame_ready` stays 0, write bank unchanged.
- **Continuous with held consumer.** Stimulus: three good frames with no `rd_done`. Required: the first is delivered (`rd_bank` = 0), the second and third each pulse `frame_drop` and write bank 1. After `rd_done`, the fourth frame is delivered with `rd_bank` = 1 and `frame_count` = 2.
- **Simultaneous events.** Stimulus: `rd_done` in the same cycle as a good-frame evaluation. Required: swap occurs, `frame_ready` remains 1, no `frame_drop`.
- **Overflow and reset.** Stimulus: a frame containing one `pix_addr` = 307200; then a separate run with `reset` asserted mid-CAPTURE. Required: in the first case that pixel is not written and `frame_err` pulses. In the second case all outputs are 0 on the next edge and the state is IDLE.
